// File: rtl/capture_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : capture_cmd_ctrl                                             |
// | Description : Host command sequencer for the capture/dump engine. Accepts  |
// |               16-bit commands {op[15:12], addr[11:8], data[7:0]} from the  |
// |               UART receiver, owns the trigger/decimator configuration      |
// |               registers and the capture_done flag, launches dumps and      |
// |               returns exactly one response byte per command.               |
// | Ports       : clk, rst_n (async, active low)                               |
// |               cmd[15:0], cmd_rdy -> clr_cmd_rdy      (command receive)      |
// |               resp[7:0], send_resp <- resp_sent      (response transmit)    |
// |               trig_type[1:0], trig_pos[8:0], dec_pwr[3:0], capture_done    |
// |               set_capture_done, start_dump, dump_finished (engine link)    |
// | Options     : CMD_DUMP_TIMEOUT_EN - dump watchdog of TO_CYCLES clocks;     |
// |               on expiry the dump is answered with NAK_BYTE.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module capture_cmd_ctrl #(
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] NAK_BYTE = 8'hEE
`ifdef CMD_DUMP_TIMEOUT_EN
  ,
  parameter int unsigned TO_CYCLES = 32'd1 << 20
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  output logic [1:0]  trig_type,
  output logic [8:0]  trig_pos,
  output logic [3:0]  dec_pwr,
  output logic        capture_done,
  input  logic        set_capture_done,
  output logic        start_dump,
  input  logic        dump_finished
);

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_READ  = 4'd2;
  localparam logic [3:0] OP_DUMP  = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_DUMP_WAIT = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        clr_cmd_rdy_q, clr_cmd_rdy_d;
  logic [7:0]  resp_q, resp_d;
  logic        send_resp_q, send_resp_d;
  logic [1:0]  trig_type_q, trig_type_d;
  logic [8:0]  trig_pos_q, trig_pos_d;
  logic [3:0]  dec_pwr_q, dec_pwr_d;
  logic        capture_done_q, capture_done_d;
  logic        start_dump_q, start_dump_d;
  logic        cd_clr;

  logic [3:0]  op;
  logic [3:0]  addr;
  logic [7:0]  data;

`ifdef CMD_DUMP_TIMEOUT_EN
  localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // The command is captured when accepted so the host side may change it as
  // soon as clr_cmd_rdy has been seen.
  assign op   = cmd_q[15:12];
  assign addr = cmd_q[11:8];
  assign data = cmd_q[7:0];

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    clr_cmd_rdy_d = 1'b0;
    resp_d        = resp_q;
    trig_type_d   = trig_type_q;
    trig_pos_d    = trig_pos_q;
    dec_pwr_d     = dec_pwr_q;
    start_dump_d  = 1'b0;
    cd_clr        = 1'b0;
`ifdef CMD_DUMP_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_rdy) begin
          cmd_d         = cmd;
          clr_cmd_rdy_d = 1'b1;
          state_d       = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_RESP;
        resp_d  = NAK_BYTE;
        case (op)
          OP_WRITE: begin
            resp_d = ACK_BYTE;
            case (addr)
              4'd0: dec_pwr_d = data[3:0];
              4'd1: begin
                trig_type_d = data[1:0];
                cd_clr      = 1'b1;  // re-arm for a fresh capture
              end
              4'd2: trig_pos_d[8]   = data[0];
              4'd3: trig_pos_d[7:0] = data;
              default: resp_d = NAK_BYTE;
            endcase
          end
          OP_READ: begin
            case (addr)
              4'd0: resp_d = {4'b0, dec_pwr_q};
              4'd1: resp_d = {5'b0, capture_done_q, trig_type_q};
              4'd2: resp_d = {7'b0, trig_pos_q[8]};
              4'd3: resp_d = trig_pos_q[7:0];
              default: resp_d = NAK_BYTE;
            endcase
          end
          OP_DUMP: begin
            // Only a completed capture can be dumped; otherwise refuse.
            if (capture_done_q) begin
              state_d      = S_DUMP_WAIT;
              start_dump_d = 1'b1;
`ifdef CMD_DUMP_TIMEOUT_EN
              to_cnt_d     = '0;
`endif
            end
          end
          default: resp_d = NAK_BYTE;
        endcase
      end

      S_DUMP_WAIT: begin
        // cmd_rdy is deliberately not looked at here; a pending command stays
        // pending until the dump has been answered.
        if (dump_finished) begin
          resp_d  = ACK_BYTE;
          state_d = S_RESP;
        end
`ifdef CMD_DUMP_TIMEOUT_EN
        else if (to_cnt_q == CNT_MAX) begin
          resp_d  = NAK_BYTE;
          state_d = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      S_RESP: begin
        if (resp_sent) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A capture completing in the same cycle as a re-arm write must not be lost.
    if (set_capture_done) begin
      capture_done_d = 1'b1;
    end else if (cd_clr) begin
      capture_done_d = 1'b0;
    end else begin
      capture_done_d = capture_done_q;
    end

    send_resp_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      clr_cmd_rdy_q  <= 1'b0;
      resp_q         <= '0;
      send_resp_q    <= 1'b0;
      trig_type_q    <= '0;
      trig_pos_q     <= '0;
      dec_pwr_q      <= '0;
      capture_done_q <= 1'b0;
      start_dump_q   <= 1'b0;
`ifdef CMD_DUMP_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      clr_cmd_rdy_q  <= clr_cmd_rdy_d;
      resp_q         <= resp_d;
      send_resp_q    <= send_resp_d;
      trig_type_q    <= trig_type_d;
      trig_pos_q     <= trig_pos_d;
      dec_pwr_q      <= dec_pwr_d;
      capture_done_q <= capture_done_d;
      start_dump_q   <= start_dump_d;
`ifdef CMD_DUMP_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
`endif
    end
  end

  assign clr_cmd_rdy  = clr_cmd_rdy_q;
  assign resp         = resp_q;
  assign send_resp    = send_resp_q;
  assign trig_type    = trig_type_q;
  assign trig_pos     = trig_pos_q;
  assign dec_pwr      = dec_pwr_q;
  assign capture_done = capture_done_q;
  assign start_dump   = start_dump_q;

endmodule
`default_nettype wire
